// File: rtl/spu_pkg.sv
// Shared SPU even-pipe definitions: opcode encodings, operation classes and
// the decode used by both the execute pipe and the issue decoder.
package spu_pkg;

  localparam int OPC_W      = 11;
  localparam int RI10_OPC_W = 8;
  localparam int IMM10_W    = 10;

  localparam logic [OPC_W-1:0] OP_AH  = 11'b00011001000;
  localparam logic [OPC_W-1:0] OP_A   = 11'b00011000000;
  localparam logic [OPC_W-1:0] OP_SFH = 11'b00001001000;
  localparam logic [OPC_W-1:0] OP_SF  = 11'b00001000000;
  localparam logic [OPC_W-1:0] OP_CLZ = 11'b01010100101;

  localparam logic [RI10_OPC_W-1:0] OP_AHI  = 8'b00011101;
  localparam logic [RI10_OPC_W-1:0] OP_AI   = 8'b00011100;
  localparam logic [RI10_OPC_W-1:0] OP_SFHI = 8'b00001101;
  localparam logic [RI10_OPC_W-1:0] OP_SFI  = 8'b00001100;

  typedef enum logic [3:0] {
    OPC_ILL,
    OPC_AH,
    OPC_AHI,
    OPC_A,
    OPC_AI,
    OPC_SFH,
    OPC_SFHI,
    OPC_SF,
    OPC_SFI,
    OPC_CLZ
  } op_class_e;

  // Full 11-bit RR encodings are tried before the 8-bit RI10 prefixes.
  function automatic op_class_e decode_op(input logic [OPC_W-1:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_AH:   cls = OPC_AH;
      OP_A:    cls = OPC_A;
      OP_SFH:  cls = OPC_SFH;
      OP_SF:   cls = OPC_SF;
      OP_CLZ:  cls = OPC_CLZ;
      default: begin
        case (opcode[OPC_W-1 -: RI10_OPC_W])
          OP_AHI:  cls = OPC_AHI;
          OP_AI:   cls = OPC_AI;
          OP_SFHI: cls = OPC_SFHI;
          OP_SFI:  cls = OPC_SFI;
          default: cls = OPC_ILL;
        endcase
      end
    endcase
    return cls;
  endfunction

  function automatic logic signed [31:0] sext_imm10(input logic [IMM10_W-1:0] imm);
    return {{(32 - IMM10_W){imm[IMM10_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fx_lane.sv
// One 32-bit lane of the fixed-point execute stage: halfword and word
// add / subtract-from (register or immediate) and count-leading-zeros.
module fx_lane
  import spu_pkg::*;
(
  input  logic        [31:0] ra,
  input  logic        [31:0] rb,
  input  logic signed [31:0] imm32,
  input  op_class_e          op_class,
  output logic        [31:0] result
);

  logic        [31:0] opb;
  logic signed [15:0] sum_hi;
  logic signed [15:0] sum_lo;
  logic signed [15:0] dif_hi;
  logic signed [15:0] dif_lo;
  logic signed [31:0] sum_w;
  logic signed [31:0] dif_w;

  function automatic logic [5:0] count_lz(input logic [31:0] w);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  // Halfword immediates use the low 16 bits of the sign-extended value in both slots.
  always_comb begin
    case (op_class)
      OPC_AHI, OPC_SFHI: opb = {imm32[15:0], imm32[15:0]};
      OPC_AI, OPC_SFI:   opb = imm32;
      default:           opb = rb;
    endcase
  end

  assign sum_hi = $signed(ra[31:16]) + $signed(opb[31:16]);
  assign sum_lo = $signed(ra[15:0])  + $signed(opb[15:0]);
  assign dif_hi = $signed(opb[31:16]) - $signed(ra[31:16]);
  assign dif_lo = $signed(opb[15:0])  - $signed(ra[15:0]);
  assign sum_w  = $signed(ra) + $signed(opb);
  assign dif_w  = $signed(opb) - $signed(ra);

  always_comb begin
    case (op_class)
      OPC_AH, OPC_AHI:   result = {sum_hi, sum_lo};
      OPC_SFH, OPC_SFHI: result = {dif_hi, dif_lo};
      OPC_A, OPC_AI:     result = sum_w;
      OPC_SF, OPC_SFI:   result = dif_w;
      OPC_CLZ:           result = {26'd0, count_lz(ra)};
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/fx_even_pipe.sv
// Pipelined SPU even-pipe fixed-point execute stage: combinational compute
// in stage 0, LATENCY registered stages carrying {valid, illegal, tag, data}.
module fx_even_pipe
  import spu_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [OPC_W-1:0]   opcode_EX,
  input  logic [DATA_W-1:0]  readDataRA_EX,
  input  logic [DATA_W-1:0]  readDataRB_EX,
  input  logic [IMM10_W-1:0] imm10,
  input  logic [TAG_W-1:0]   rt_in,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [DATA_W-1:0]  result_EX,
  output logic [TAG_W-1:0]   rt_out,
  output logic               illegal_op,
  output logic [2:0]         latency_EX,
  output logic               busy
);

  localparam int LANES = DATA_W / 32;

  typedef struct packed {
    logic              vld;
    logic              ill;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } stage_t;

  if ((DATA_W % 32) != 0 || DATA_W < 32) begin : g_bad_width
    $error("fx_even_pipe: DATA_W must be a positive multiple of 32");
  end
  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("fx_even_pipe: LATENCY must be in 1..7");
  end

  op_class_e          op_class_p0;
  logic               ill_p0;
  logic signed [31:0] imm32_p0;
  logic [DATA_W-1:0]  lane_res_p0;
  stage_t             in_p0;
  stage_t             stage_p [LATENCY];
  logic [LATENCY-1:0] vld_all;

  // Stage 0: decode and lane compute, purely combinational.
  assign op_class_p0 = decode_op(opcode_EX);
  assign ill_p0      = (op_class_p0 == OPC_ILL);
  assign imm32_p0    = sext_imm10(imm10);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fx_lane u_lane (
      .ra       (readDataRA_EX[l*32 +: 32]),
      .rb       (readDataRB_EX[l*32 +: 32]),
      .imm32    (imm32_p0),
      .op_class (op_class_p0),
      .result   (lane_res_p0[l*32 +: 32])
    );
  end

  always_comb begin
    in_p0.vld  = in_valid;
    in_p0.ill  = in_valid & ill_p0;
    in_p0.tag  = rt_in;
    in_p0.data = ill_p0 ? '0 : lane_res_p0;
  end

  // Stages 1..LATENCY: stage 1 captures the compute, the rest are delay.
  // Flush outranks stall and issue; stall freezes every stage together.
  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    stage_t stage_d;

    if (s == 0) begin : g_head
      assign stage_d = in_p0;
    end else begin : g_tail
      assign stage_d = stage_p[s-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        stage_p[s] <= '0;
      end else if (flush) begin
        stage_p[s].vld <= 1'b0;
        stage_p[s].ill <= 1'b0;
      end else if (!stall) begin
        stage_p[s] <= stage_d;
      end
    end

    assign vld_all[s] = stage_p[s].vld;
  end

  // Output: straight from the last stage register.
  assign out_valid  = stage_p[LATENCY-1].vld;
  assign illegal_op = stage_p[LATENCY-1].ill;
  assign rt_out     = stage_p[LATENCY-1].tag;
  assign result_EX  = stage_p[LATENCY-1].data;
  assign busy       = |vld_all;
  assign latency_EX = 3'(LATENCY);

endmodule

// File: tb/tb_fx_even_pipe.sv
// Randomized self-checking bench for fx_even_pipe with a lane-arithmetic
// reference model and an in-order expected-result queue.
module tb_fx_even_pipe;

  localparam int DATA_W  = 128;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 7;
  localparam int LANES   = DATA_W / 32;
  localparam int HWS     = DATA_W / 16;

  localparam logic [10:0] C_AH   = 11'b00011001000;
  localparam logic [10:0] C_A    = 11'b00011000000;
  localparam logic [10:0] C_SFH  = 11'b00001001000;
  localparam logic [10:0] C_SF   = 11'b00001000000;
  localparam logic [10:0] C_CLZ  = 11'b01010100101;
  localparam logic [7:0]  C_AHI  = 8'b00011101;
  localparam logic [7:0]  C_AI   = 8'b00011100;
  localparam logic [7:0]  C_SFHI = 8'b00001101;
  localparam logic [7:0]  C_SFI  = 8'b00001100;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [10:0]       opcode_EX;
  logic [DATA_W-1:0] readDataRA_EX;
  logic [DATA_W-1:0] readDataRB_EX;
  logic [9:0]        imm10;
  logic [TAG_W-1:0]  rt_in;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] result_EX;
  logic [TAG_W-1:0]  rt_out;
  logic              illegal_op;
  logic [2:0]        latency_EX;
  logic              busy;

  typedef struct {
    logic              ill;
    logic [TAG_W-1:0]  rt;
    logic [DATA_W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fx_even_pipe #(.DATA_W(DATA_W), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .opcode_EX     (opcode_EX),
    .readDataRA_EX (readDataRA_EX),
    .readDataRB_EX (readDataRB_EX),
    .imm10         (imm10),
    .rt_in         (rt_in),
    .stall         (stall),
    .flush         (flush),
    .out_valid     (out_valid),
    .result_EX     (result_EX),
    .rt_out        (rt_out),
    .illegal_op    (illegal_op),
    .latency_EX    (latency_EX),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: each op expressed as plain integer arithmetic on slots.
  function automatic void model(input logic [10:0] op, input logic [DATA_W-1:0] ra,
                                input logic [DATA_W-1:0] rb, input logic [9:0] imm,
                                output logic ill, output logic [DATA_W-1:0] res);
    int         simm;
    int         kind;
    logic [7:0] ri;
    simm = imm[9] ? int'(imm) - 1024 : int'(imm);
    ri   = op[10:3];
    ill  = 1'b0;
    res  = '0;
    if (op == C_AH)         kind = 0;
    else if (op == C_A)     kind = 1;
    else if (op == C_SFH)   kind = 2;
    else if (op == C_SF)    kind = 3;
    else if (op == C_CLZ)   kind = 4;
    else if (ri == C_AHI)   kind = 5;
    else if (ri == C_AI)    kind = 6;
    else if (ri == C_SFHI)  kind = 7;
    else if (ri == C_SFI)   kind = 8;
    else                    kind = 9;
    if (kind == 9) begin
      ill = 1'b1;
      return;
    end
    for (int h = 0; h < HWS; h++) begin
      int a;
      int b;
      a = int'(ra[h*16 +: 16]);
      b = int'(rb[h*16 +: 16]);
      case (kind)
        0: res[h*16 +: 16] = 16'(a + b);
        2: res[h*16 +: 16] = 16'(b - a);
        5: res[h*16 +: 16] = 16'(a + simm);
        7: res[h*16 +: 16] = 16'(simm - a);
        default: ;
      endcase
    end
    for (int w = 0; w < LANES; w++) begin
      longint a;
      longint b;
      logic [31:0] word;
      int n;
      a    = longint'(ra[w*32 +: 32]);
      b    = longint'(rb[w*32 +: 32]);
      word = ra[w*32 +: 32];
      n    = 0;
      while (n < 32 && word[31-n] == 1'b0) n++;
      case (kind)
        1: res[w*32 +: 32] = 32'(a + b);
        3: res[w*32 +: 32] = 32'(b - a);
        4: res[w*32 +: 32] = 32'(n);
        6: res[w*32 +: 32] = 32'(a + longint'(simm));
        8: res[w*32 +: 32] = 32'(longint'(simm) - a);
        default: ;
      endcase
    end
  endfunction

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 40);
    return v;
  endfunction

  function automatic logic [10:0] rand_op();
    logic [10:0] op;
    case ($urandom_range(0, 9))
      0: op = C_AH;
      1: op = C_A;
      2: op = C_SFH;
      3: op = C_SF;
      4: op = C_CLZ;
      5: op = {C_AHI, 3'($urandom)};
      6: op = {C_AI, 3'($urandom)};
      7: op = {C_SFHI, 3'($urandom)};
      8: op = {C_SFI, 3'($urandom)};
      default: op = {8'hFF, 3'($urandom)};
    endcase
    return op;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [10:0] op, input logic [DATA_W-1:0] ra,
                       input logic [DATA_W-1:0] rb, input logic [9:0] imm,
                       input logic [TAG_W-1:0] rt, input logic v);
    opcode_EX     = op;
    readDataRA_EX = ra;
    readDataRB_EX = rb;
    imm10         = imm;
    rt_in         = rt;
    in_valid      = v;
  endtask

  task automatic run_single(input logic [10:0] op, input logic [DATA_W-1:0] ra,
                            input logic [DATA_W-1:0] rb, input logic [9:0] imm,
                            input logic [TAG_W-1:0] rt, output logic v, output logic il,
                            output logic [DATA_W-1:0] res, output logic [TAG_W-1:0] rto,
                            output int lat);
    drive(op, ra, rb, imm, rt, 1'b1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < LATENCY + 4) begin
      tick();
      lat++;
    end
    v   = out_valid;
    il  = illegal_op;
    res = result_EX;
    rto = rt_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(C_AH, '1, '1, 10'd0, 7'd3, 1'b1);
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else n_pass++;
    n_checks++;
    if (illegal_op !== 1'b0) $display("FAIL reset_illegal got=%b want=0", illegal_op);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else n_pass++;
    n_checks++;
    if (result_EX !== '0 || rt_out !== '0)
      $display("FAIL reset_data got res=%h rt=%h want 0", result_EX, rt_out);
    else n_pass++;
    n_checks++;
    if (latency_EX !== 3'(LATENCY)) $display("FAIL latency_EX got=%0d want=%0d", latency_EX, LATENCY);
    else n_pass++;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_ah_carry();
    logic [DATA_W-1:0] ra, rb, res;
    logic v, il;
    logic [TAG_W-1:0] rto;
    int lat;
    for (int h = 0; h < HWS; h++) begin
      ra[h*16 +: 16] = 16'hFFFF;
      rb[h*16 +: 16] = 16'h0001;
    end
    run_single(C_AH, ra, rb, 10'd0, 7'h2A, v, il, res, rto, lat);
    n_checks++;
    if (v !== 1'b1 || lat != LATENCY) $display("FAIL ah_latency got v=%b lat=%0d want v=1 lat=%0d", v, lat, LATENCY);
    else n_pass++;
    n_checks++;
    if (res !== '0 || il !== 1'b0) $display("FAIL ah_wrap got=%h ill=%b want=0 ill=0", res, il);
    else n_pass++;
    n_checks++;
    if (rto !== 7'h2A) $display("FAIL ah_tag got=%h want=2a", rto);
    else n_pass++;
  endtask

  task automatic test_immediates();
    logic [DATA_W-1:0] ra, res, want, mres;
    logic v, il, mill;
    logic [TAG_W-1:0] rto;
    int lat;
    for (int w = 0; w < LANES; w++) begin
      ra[w*32 +: 32]   = 32'd5;
      want[w*32 +: 32] = 32'hFFFFFFFA;
    end
    run_single({C_SFI, 3'b101}, ra, rand_vec(), 10'h3FF, 7'd11, v, il, res, rto, lat);
    n_checks++;
    if (v !== 1'b1 || res !== want || il !== 1'b0) $display("FAIL sfi_minus1 got=%h want=%h", res, want);
    else n_pass++;
    ra = '0;
    for (int h = 0; h < HWS; h++) want[h*16 +: 16] = 16'hFE00;
    run_single({C_AHI, 3'b010}, ra, rand_vec(), 10'h200, 7'd12, v, il, res, rto, lat);
    n_checks++;
    if (v !== 1'b1 || res !== want) $display("FAIL ahi_neg512 got=%h want=%h", res, want);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      logic [10:0] op;
      logic [9:0]  imm;
      op  = (k == 0) ? {C_AHI, 3'd0} : (k == 1) ? {C_AI, 3'd7} : (k == 2) ? {C_SFHI, 3'd3} : {C_SFI, 3'd1};
      imm = 10'($urandom);
      ra  = rand_vec();
      model(op, ra, '0, imm, mill, mres);
      run_single(op, ra, rand_vec(), imm, 7'(k), v, il, res, rto, lat);
      n_checks++;
      if (v !== 1'b1 || res !== mres || il !== mill)
        $display("FAIL imm_rand%0d got=%h want=%h", k, res, mres);
      else n_pass++;
    end
  endtask

  task automatic test_clz();
    logic [DATA_W-1:0] ra, res, want;
    logic v, il;
    logic [TAG_W-1:0] rto;
    logic [31:0] pat [4];
    logic [31:0] cnt [4];
    int lat;
    pat[0] = 32'h0;        cnt[0] = 32'd32;
    pat[1] = 32'h80000000; cnt[1] = 32'd0;
    pat[2] = 32'h1;        cnt[2] = 32'd31;
    pat[3] = 32'h0000FFFF; cnt[3] = 32'd16;
    for (int w = 0; w < LANES; w++) begin
      ra[w*32 +: 32]   = pat[w % 4];
      want[w*32 +: 32] = cnt[w % 4];
    end
    run_single(C_CLZ, ra, rand_vec(), 10'd0, 7'h55, v, il, res, rto, lat);
    n_checks++;
    if (v !== 1'b1 || res !== want || rto !== 7'h55) $display("FAIL clz_words got=%h want=%h", res, want);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [DATA_W-1:0] res;
    logic v, il;
    logic [TAG_W-1:0] rto;
    int lat;
    run_single(11'h7FF, rand_vec(), rand_vec(), 10'h155, 7'h7F, v, il, res, rto, lat);
    n_checks++;
    if (v !== 1'b1 || il !== 1'b1) $display("FAIL illegal_flag got v=%b ill=%b want 1 1", v, il);
    else n_pass++;
    n_checks++;
    if (res !== '0 || rto !== 7'h7F) $display("FAIL illegal_result got=%h rt=%h want 0 rt=7f", res, rto);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    exp_t e;
    int   consumed = 0;
    idle(LATENCY + 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      bit active;
      active = (cyc < 160);
      drive(rand_op(), rand_vec(), rand_vec(), 10'($urandom), 7'($urandom),
            active && ($urandom_range(0, 3) != 0));
      stall = active && ($urandom_range(0, 4) == 0);
      if (out_valid === 1'b1 && !stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra unexpected result rt=%h", rt_out);
        end else begin
          e = exp_q.pop_front();
          consumed++;
          if (illegal_op !== e.ill || rt_out !== e.rt || result_EX !== e.res)
            $display("FAIL stream_op%0d got ill=%b rt=%h res=%h want ill=%b rt=%h res=%h",
                     consumed, illegal_op, rt_out, result_EX, e.ill, e.rt, e.res);
          else n_pass++;
        end
      end
      if (in_valid && !stall) begin
        model(opcode_EX, readDataRA_EX, readDataRB_EX, imm10, e.ill, e.res);
        e.rt = rt_in;
        exp_q.push_back(e);
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stream_lost got %0d outstanding want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back_stall();
    exp_t e;
    logic [10:0]              ops [4];
    logic [DATA_W+TAG_W:0]    snap;
    int consumed = 0;
    ops[0] = C_AH;
    ops[1] = C_SF;
    ops[2] = {C_SFI, 3'd0};
    ops[3] = C_CLZ;
    idle(LATENCY + 1);
    for (int cyc = 0; cyc < 7 + LATENCY + 4; cyc++) begin
      if (cyc < 4) begin
        drive(ops[cyc], rand_vec(), rand_vec(), 10'($urandom), 7'(40 + cyc), 1'b1);
        stall = 1'b0;
      end else if (cyc < 7) begin
        drive(C_A, rand_vec(), rand_vec(), 10'($urandom), 7'h77, 1'b1);
        stall = 1'b1;
      end else begin
        in_valid = 1'b0;
        stall    = 1'b0;
      end
      if (cyc == 4) snap = {out_valid, rt_out, result_EX};
      if (cyc >= 5 && cyc <= 7) begin
        n_checks++;
        if ({out_valid, rt_out, result_EX} !== snap)
          $display("FAIL stall_frozen cyc%0d got v=%b rt=%h want v=%b rt=%h",
                   cyc, out_valid, rt_out, snap[DATA_W+TAG_W], snap[DATA_W +: TAG_W]);
        else n_pass++;
      end
      if (out_valid === 1'b1 && !stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra unexpected result rt=%h", rt_out);
        end else begin
          e = exp_q.pop_front();
          consumed++;
          if (illegal_op !== e.ill || rt_out !== e.rt || result_EX !== e.res)
            $display("FAIL b2b_op%0d got rt=%h res=%h want rt=%h res=%h",
                     consumed, rt_out, result_EX, e.rt, e.res);
          else n_pass++;
        end
      end
      if (in_valid && !stall) begin
        model(opcode_EX, readDataRA_EX, readDataRB_EX, imm10, e.ill, e.res);
        e.rt = rt_in;
        exp_q.push_back(e);
      end
      tick();
    end
    n_checks++;
    if (consumed != 4 || exp_q.size() != 0)
      $display("FAIL b2b_count got %0d results want 4", consumed);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    int seen = 0;
    idle(LATENCY + 1);
    drive(C_A, rand_vec(), rand_vec(), 10'd0, 7'd1, 1'b1);
    tick();
    drive(C_SFH, rand_vec(), rand_vec(), 10'd0, 7'd2, 1'b1);
    tick();
    drive(C_AH, rand_vec(), rand_vec(), 10'd0, 7'd3, 1'b1);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL flush_clear got busy=%b v=%b want 0 0", busy, out_valid);
    else n_pass++;
    for (int i = 0; i < LATENCY + 2; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL flush_leak got %0d valid cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_midpipe();
    int seen = 0;
    idle(LATENCY + 1);
    drive(C_A, rand_vec(), rand_vec(), 10'd0, 7'd9, 1'b1);
    tick();
    drive(C_CLZ, rand_vec(), rand_vec(), 10'd0, 7'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_valid got v=%b busy=%b want 0 0", out_valid, busy);
    else n_pass++;
    n_checks++;
    if (result_EX !== '0 || rt_out !== '0 || illegal_op !== 1'b0)
      $display("FAIL midreset_data got res=%h rt=%h want 0", result_EX, rt_out);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL midreset_leak got %0d valid cycles want 0", seen);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(11'd0, '0, '0, 10'd0, '0, 1'b0);
    test_reset();
    test_ah_carry();
    test_immediates();
    test_clz();
    test_illegal();
    test_random_stream();
    test_back_to_back_stall();
    test_flush();
    test_reset_midpipe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
